memory_cycle: RTL

Memory stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM register outputs of the execute stage and performs loads and stores on an external data-memory bus with a request/acknowledge handshake, so the memory may insert wait states. Raises a stall to the hazard unit while an access is outstanding, then registers the MEM/WB bundle for writeback.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/dmem_access_fsm.sv | 95 +++++++++
 rtl/memory_cycle.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types shared by the memory stage and its access FSM.
//   mem_state_e   - data-memory access FSM states
//   mem_wb_t      - MEM/WB pipeline register contents (control + data)
//   BUBBLE_MEM_WB - all-zero MEM/WB value, used at reset
package pipeline_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic        result_src;
        logic        mem_err;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } mem_wb_t;

    localparam mem_wb_t BUBBLE_MEM_WB = '0;

endpackage

// File: rtl/dmem_access_fsm.sv
// dmem_access_fsm: request/acknowledge sequencing for the data-memory bus.
// Optional feature macro: MEMORY_CYCLE_TIMEOUT_EN (wait counter + abort).
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   access     - MEM-stage instruction is a load or store
//   dmem_ack   - memory completes the access this cycle
//   dmem_req   - access request to the memory
//   stall      - hold upstream stages this cycle
//   abort      - access timed out this cycle (always 0 without the feature)
module dmem_access_fsm
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic stall,
    output logic abort
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_access_fsm: TIMEOUT_CYCLES must be in 2..255");
    end

    mem_state_e state_q;
    mem_state_e state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEMORY_CYCLE_TIMEOUT_EN
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    // Counts wait-state cycles already spent on the access. The IDLE cycle
    // that first sees no ack is itself a wait state, so WAIT is entered
    // with a count of 1; the abort cycle is wait state number TIMEOUT_CYCLES.
    logic [7:0] wait_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == MEM_IDLE) begin
            wait_cnt_q <= 8'd1;
        end else if (!dmem_ack) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    assign abort = rst && (state_q == MEM_WAIT) && (wait_cnt_q == LAST_WAIT) && !dmem_ack;
`else
    assign abort = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                dmem_req = access;
                stall    = access && !dmem_ack;
                if (access && !dmem_ack) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                stall    = access && !dmem_ack && !abort;
                if (dmem_ack || abort) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        // Outputs are forced low while reset is held, even though the
        // M inputs may still present an access.
        if (!rst) begin
            dmem_req = 1'b0;
            stall    = 1'b0;
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the 5-stage RISC-V pipeline. Issues loads and
// stores on a req/ack data-memory bus, stalls upstream while an access is
// outstanding, and owns the MEM/WB register.
// Optional feature macro: MEMORY_CYCLE_TIMEOUT_EN (abort after TIMEOUT_CYCLES
// wait states, retiring the instruction as a bubble with MemErrW pulsed).
// Ports:
//   clk, rst                     - clock, asynchronous active-low reset
//   RegWriteM..ALU_ResultM       - EX/MEM register outputs
//   dmem_req/we/addr/wdata       - data-memory request side
//   dmem_ack, dmem_rdata         - data-memory response side
//   StallM                       - hold IF/ID/EX/EX-MEM this cycle
//   RegWriteW..ReadDataW, MemErrW- MEM/WB register outputs
module memory_cycle
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MemErrW
);

    logic    access;
    logic    abort;
    mem_wb_t wb_q;

    assign access = MemWriteM | ResultSrcM;

    dmem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .access   (access),
        .dmem_ack (dmem_ack),
        .dmem_req (dmem_req),
        .stall    (StallM),
        .abort    (abort)
    );

    // Upstream holds the M inputs while stalled, so the bus fields are
    // driven straight from them; they are zeroed only while in reset.
    assign dmem_we    = dmem_req & MemWriteM;
    assign dmem_addr  = {32{rst}} & ALU_ResultM;
    assign dmem_wdata = {32{rst}} & WriteDataM;

    // NOTE: MEM/WB is a handful of flops, not a RAM array, so it takes the
    // async reset like any other control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= BUBBLE_MEM_WB;
        end else if (StallM) begin
            // Bubble: only the fields that could cause side effects clear.
            wb_q.reg_write <= 1'b0;
            wb_q.mem_err   <= 1'b0;
        end else if (abort) begin
            wb_q.reg_write <= 1'b0;
            wb_q.mem_err   <= 1'b1;
        end else begin
            wb_q.reg_write  <= RegWriteM;
            wb_q.result_src <= ResultSrcM;
            wb_q.mem_err    <= 1'b0;
            wb_q.rd         <= RD_M;
            wb_q.pc_plus4   <= PCPlus4M;
            wb_q.alu_result <= ALU_ResultM;
            if (ResultSrcM) begin
                wb_q.read_data <= dmem_rdata;
            end
        end
    end

    assign RegWriteW   = wb_q.reg_write;
    assign ResultSrcW  = wb_q.result_src;
    assign RD_W        = wb_q.rd;
    assign PCPlus4W    = wb_q.pc_plus4;
    assign ALU_ResultW = wb_q.alu_result;
    assign ReadDataW   = wb_q.read_data;
    assign MemErrW     = wb_q.mem_err;

endmodule
